// File: rtl/ssd_pattern_decoder.sv
// ssd_pattern_decoder
// Seven-segment receiver. Samples an 8-bit segment bus, waits until a pattern
// has been stable long enough, and decodes it back into a hex nibble plus DP.
// It also flags blank and illegal patterns and counts accepted changes.
//
// Ports:
//   Clk          system clock
//   Rst          synchronous active-high reset
//   En           master enable; low freezes acceptance and restarts settling
//   SSD_In[7:0]  raw segment bus, bit0=A .. bit6=G, bit7=DP (asynchronous)
//   Digit[3:0]   last accepted valid hex value
//   DP_Out       DP of the last accepted pattern (active-high)
//   Valid        locked pattern is one of the 16 hex glyphs
//   Blank        locked pattern has segments A-G all off
//   Invalid      locked pattern is neither a glyph nor blank
//   Strobe       one-cycle pulse when a new pattern is locked
//   ChangeCount  number of Strobes since reset, saturating at 255
//   SeqErr       pulses with Strobe when a newly locked glyph is not the
//                previous glyph + 1 (mod 16)
//
// Parameters:
//   SSD_TYPE       0 = common anode (active-low bus), 1 = common cathode
//   STABLE_CYCLES  identical samples required before a pattern is accepted
//
// Build option:
//   SSD_SEQ_CHECK_EN  builds the sequence checker behind SeqErr; without it
//                     SeqErr is tied low.

module ssd_pattern_decoder #(
  parameter int SSD_TYPE      = 0,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       En,
  input  logic [7:0] SSD_In,
  output logic [3:0] Digit,
  output logic       DP_Out,
  output logic       Valid,
  output logic       Blank,
  output logic       Invalid,
  output logic       Strobe,
  output logic [7:0] ChangeCount,
  output logic       SeqErr
);

  localparam int CntW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);
  localparam logic [7:0] IdleLevel = (SSD_TYPE == 0) ? 8'hFF : 8'h00;

  typedef enum logic {SETTLING, LOCKED} state_t;

  logic [7:0]      sync1_q, sync2_q;
  logic [7:0]      pattern;
  state_t          state_q, state_d;
  logic [7:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      lockPat_q, lockPat_d;
  logic [3:0]      digit_q, digit_d;
  logic            dp_q, dp_d;
  logic            valid_q, valid_d;
  logic            blank_q, blank_d;
  logic            invalid_q, invalid_d;
  logic            strobe_q, strobe_d;
  logic [7:0]      count_q, count_d;
  logic            candGlyph;
  logic [3:0]      candDigit;
`ifdef SSD_SEQ_CHECK_EN
  logic [3:0]      refDigit_q, refDigit_d;
  logic            refValid_q, refValid_d;
  logic            seqErr_q, seqErr_d;
`endif

  // Everything inside is active-high segments regardless of display type.
  assign pattern = (SSD_TYPE == 0) ? ~sync2_q : sync2_q;

  // Glyph lookup on the candidate; DP (bit 7) never affects classification.
  always_comb begin
    candGlyph = 1'b1;
    candDigit = 4'h0;
    case (cand_q[6:0])
      7'h3F: candDigit = 4'h0;
      7'h06: candDigit = 4'h1;
      7'h5B: candDigit = 4'h2;
      7'h4F: candDigit = 4'h3;
      7'h66: candDigit = 4'h4;
      7'h6D: candDigit = 4'h5;
      7'h7D: candDigit = 4'h6;
      7'h07: candDigit = 4'h7;
      7'h7F: candDigit = 4'h8;
      7'h6F: candDigit = 4'h9;
      7'h77: candDigit = 4'hA;
      7'h7C: candDigit = 4'hB;
      7'h39: candDigit = 4'hC;
      7'h5E: candDigit = 4'hD;
      7'h79: candDigit = 4'hE;
      7'h71: candDigit = 4'hF;
      default: candGlyph = 1'b0;
    endcase
  end

  // Next-state logic. A changed sample always reloads the candidate, which
  // is why a change on the would-be lock edge wins over the lock. Locking a
  // pattern equal to the one already locked (a glitch that came back) is
  // silent.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    lockPat_d = lockPat_q;
    digit_d   = digit_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    blank_d   = blank_q;
    invalid_d = invalid_q;
    strobe_d  = 1'b0;
    count_d   = count_q;
`ifdef SSD_SEQ_CHECK_EN
    refDigit_d = refDigit_q;
    refValid_d = refValid_q;
    seqErr_d   = 1'b0;
`endif
    if (!En || (pattern != cand_q)) begin
      cand_d  = pattern;
      cnt_d   = '0;
      state_d = SETTLING;
    end else if (state_q == SETTLING) begin
      if (cnt_q < CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end else begin
        state_d = LOCKED;
        if (cand_q != lockPat_q) begin
          lockPat_d = cand_q;
          strobe_d  = 1'b1;
          dp_d      = cand_q[7];
          valid_d   = candGlyph;
          blank_d   = (cand_q[6:0] == 7'h00);
          invalid_d = !candGlyph && (cand_q[6:0] != 7'h00);
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
          if (candGlyph) begin
            digit_d = candDigit;
`ifdef SSD_SEQ_CHECK_EN
            seqErr_d   = refValid_q && (candDigit != refDigit_q + 4'd1);
            refDigit_d = candDigit;
            refValid_d = 1'b1;
`endif
          end
        end
      end
    end
  end

  // State registers, including the two-flop synchroniser that loads the
  // display's blank idle level on reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q   <= IdleLevel;
      sync2_q   <= IdleLevel;
      state_q   <= LOCKED;
      cand_q    <= 8'h00;
      cnt_q     <= '0;
      lockPat_q <= 8'h00;
      digit_q   <= 4'h0;
      dp_q      <= 1'b0;
      valid_q   <= 1'b0;
      blank_q   <= 1'b1;
      invalid_q <= 1'b0;
      strobe_q  <= 1'b0;
      count_q   <= 8'h00;
`ifdef SSD_SEQ_CHECK_EN
      refDigit_q <= 4'h0;
      refValid_q <= 1'b0;
      seqErr_q   <= 1'b0;
`endif
    end else begin
      sync1_q   <= SSD_In;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      lockPat_q <= lockPat_d;
      digit_q   <= digit_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      invalid_q <= invalid_d;
      strobe_q  <= strobe_d;
      count_q   <= count_d;
`ifdef SSD_SEQ_CHECK_EN
      refDigit_q <= refDigit_d;
      refValid_q <= refValid_d;
      seqErr_q   <= seqErr_d;
`endif
    end
  end

  assign Digit       = digit_q;
  assign DP_Out      = dp_q;
  assign Valid       = valid_q;
  assign Blank       = blank_q;
  assign Invalid     = invalid_q;
  assign Strobe      = strobe_q;
  assign ChangeCount = count_q;
`ifdef SSD_SEQ_CHECK_EN
  assign SeqErr      = seqErr_q;
`else
  assign SeqErr      = 1'b0;
`endif

endmodule

// File: tb/tb_ssd_pattern_decoder.sv
// tb_ssd_pattern_decoder
// Self-checking bench for ssd_pattern_decoder (common anode, 4 stable
// samples). Each pattern that should lock pushes its expected outputs onto a
// queue; a monitor pops and compares on every Strobe.

module tb_ssd_pattern_decoder;

  localparam int StableCycles = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       En;
  logic [7:0] SSD_In;
  logic [3:0] Digit;
  logic       DP_Out, Valid, Blank, Invalid, Strobe, SeqErr;
  logic [7:0] ChangeCount;

  typedef struct packed {
    logic [3:0] digit;
    logic       dp;
    logic       valid;
    logic       blank;
    logic       invalid;
    logic       seqErr;
    logic [7:0] count;
  } expect_t;

  expect_t expQ[$];
  int assertCount = 0;
  int failCount = 0;
  int edgeCount = 0;
  int lastStrobeEdge = -1;
  int startEdge;

  logic [6:0] glyphTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                7'h39, 7'h5E, 7'h79, 7'h71};

  logic [7:0] mLockPat;
  logic [3:0] mDigit;
  logic       mDp, mValid, mBlank, mInvalid;
  int         mCount;
  logic [3:0] mRef;
  logic       mRefValid;

  ssd_pattern_decoder #(.SSD_TYPE(0), .STABLE_CYCLES(StableCycles)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .SSD_In(SSD_In),
    .Digit(Digit), .DP_Out(DP_Out), .Valid(Valid), .Blank(Blank),
    .Invalid(Invalid), .Strobe(Strobe), .ChangeCount(ChangeCount),
    .SeqErr(SeqErr)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) edgeCount++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: every Strobe must match the oldest pending expectation.
  always @(negedge Clk) begin
    expect_t e;
    if (Strobe === 1'b1) begin
      lastStrobeEdge = edgeCount;
      if (expQ.size() == 0) begin
        checkOutput("unexpected strobe", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("digit", Digit, e.digit);
        checkOutput("dp", DP_Out, e.dp);
        checkOutput("valid", Valid, e.valid);
        checkOutput("blank", Blank, e.blank);
        checkOutput("invalid", Invalid, e.invalid);
        checkOutput("seqerr", SeqErr, e.seqErr);
        checkOutput("count", ChangeCount, e.count);
      end
    end else if (SeqErr !== 1'b0) begin
      checkOutput("seqerr without strobe", SeqErr, 32'd0);
    end
  end

  function automatic logic [7:0] rawOf(input int idx, input logic dp);
    logic [7:0] p;
    p = {dp, glyphTab[idx]};
    return ~p;
  endfunction

  task automatic modelReset();
    mLockPat = 8'h00; mDigit = 4'h0; mDp = 1'b0; mValid = 1'b0;
    mBlank = 1'b1; mInvalid = 1'b0; mCount = 0; mRef = 4'h0; mRefValid = 1'b0;
  endtask

  // Predicts the outputs for a raw pattern that will be held until it locks.
  task automatic predict(input logic [7:0] raw);
    logic [7:0] p;
    expect_t e;
    int idx;
    logic seq;
    p = ~raw;
    if (p == mLockPat) return;
    mLockPat = p;
    idx = -1;
    for (int i = 0; i < 16; i++) if (glyphTab[i] == p[6:0]) idx = i;
    mDp = p[7];
    mValid = (idx >= 0);
    mBlank = (p[6:0] == 7'h00);
    mInvalid = !mValid && !mBlank;
    if (mCount < 255) mCount++;
    seq = 1'b0;
    if (mValid) begin
      mDigit = idx[3:0];
`ifdef SSD_SEQ_CHECK_EN
      seq = mRefValid && (idx[3:0] != 4'((mRef + 1) % 16));
      mRef = idx[3:0];
      mRefValid = 1'b1;
`endif
    end
    e.digit = mDigit; e.dp = mDp; e.valid = mValid; e.blank = mBlank;
    e.invalid = mInvalid; e.seqErr = seq; e.count = 8'(mCount);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] raw, input int cycles);
    SSD_In = raw;
    repeat (cycles) @(posedge Clk);
    #1;
  endtask

  task automatic lockPattern(input logic [7:0] raw);
    predict(raw);
    applyStimulus(raw, 10);
    checkOutput("strobe seen", expQ.size(), 32'd0);
    expQ.delete();
  endtask

  task automatic checkReset();
    checkOutput("rst digit", Digit, 32'h0);
    checkOutput("rst dp", DP_Out, 32'h0);
    checkOutput("rst valid", Valid, 32'h0);
    checkOutput("rst blank", Blank, 32'h1);
    checkOutput("rst invalid", Invalid, 32'h0);
    checkOutput("rst strobe", Strobe, 32'h0);
    checkOutput("rst count", ChangeCount, 32'h0);
    checkOutput("rst seqerr", SeqErr, 32'h0);
  endtask

  task automatic pulseReset(input int cycles);
    Rst = 1'b1;
    applyStimulus(SSD_In, cycles);
    checkReset();
    modelReset();
    Rst = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; En = 1'b1; SSD_In = 8'hFF;
    modelReset();
    pulseReset(3);

    // Lock glyph 0 and confirm the settle latency.
    applyStimulus(8'hFF, 2);
    startEdge = edgeCount;
    predict(8'hC0);
    applyStimulus(8'hC0, 10);
    checkOutput("t1 latency", lastStrobeEdge - startEdge, StableCycles + 3);
    checkOutput("t1 strobe seen", expQ.size(), 32'd0);

    // Short glitch back to the locked glyph 5.
    lockPattern(8'h92);
    applyStimulus(8'h82, 3);
    applyStimulus(8'h92, 10);
    checkOutput("t2 digit", Digit, 32'h5);
    checkOutput("t2 count", ChangeCount, mCount);

    // Invalid then blank; Digit must hold.
    lockPattern(8'hB6);
    checkOutput("t3 digit hold", Digit, 32'h5);
    lockPattern(8'hFF);
    checkOutput("t3 blank digit hold", Digit, 32'h5);

    // Disabled acceptance, then re-enable.
    lockPattern(8'hF9);
    En = 1'b0;
    applyStimulus(8'hF8, 20);
    predict(8'hF8);
    En = 1'b1;
    applyStimulus(8'hF8, 10);
    checkOutput("t4 strobe seen", expQ.size(), 32'd0);
    checkOutput("t4 digit", Digit, 32'h7);

    // DP participates in the pattern.
    lockPattern(rawOf(8, 1'b1));
    lockPattern(rawOf(8, 1'b0));

    // Reset in the middle of settling, then full re-acquisition.
    applyStimulus(8'hB0, 5);
    pulseReset(1);
    predict(8'hB0);
    applyStimulus(8'hB0, 12);
    checkOutput("t5 strobe seen", expQ.size(), 32'd0);
    checkOutput("t5 count", ChangeCount, 32'd1);

    // Sequence checks from a fresh reset.
    applyStimulus(8'hFF, 2);
    pulseReset(1);
    applyStimulus(8'hFF, 4);
    lockPattern(rawOf(0, 1'b0));
    lockPattern(rawOf(1, 1'b0));
    lockPattern(rawOf(2, 1'b0));
    lockPattern(rawOf(4, 1'b0));
    lockPattern(rawOf(14, 1'b0));
    lockPattern(rawOf(15, 1'b0));
    lockPattern(rawOf(0, 1'b0));
    lockPattern(rawOf(3, 1'b0));
    lockPattern(8'hFF);
    lockPattern(rawOf(4, 1'b0));

    // Drive enough changes to saturate the counter.
    for (int i = 0; i < 250; i++) lockPattern(rawOf(i % 2 + 1, 1'b0));
    checkOutput("count saturated", ChangeCount, 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
